// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared constants and types for the score display scanner.
//   NUM_DIGITS       : number of multiplexed digits.
//   seg_t            : segment vector {g,f,e,d,c,b,a}, active-low.
//   SEG_0..SEG_9     : decimal digit patterns.
//   SEG_BLANK        : all segments off.
//   SEG_DASH         : middle bar only, shown for invalid BCD nibbles.
package score_display_pkg;

  localparam int NUM_DIGITS = 5;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// bcd_to_seven_seg
// Combinational decoder from one BCD nibble to an active-low segment vector.
//   nib   : BCD digit; 10..15 are shown as a dash.
//   blank : forces all segments off (leading-zero suppression).
//   seg   : {g,f,e,d,c,b,a}, active-low.
module bcd_to_seven_seg
  import score_display_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// score_display_scanner
// Scans a 5-digit multiplexed seven-segment display showing a packed-BCD
// score. The score is snapshotted once per frame, leading zeros are blanked
// and the digit/segment outputs are produced by a two-stage pipeline.
// Optional best-score tracking is compiled in with SCORE_DISPLAY_BEST_EN.
//   clk, rst    : clock, synchronous active-high reset.
//   bcd_score   : current score, 5 BCD nibbles, [3:0] least significant.
//   show_best   : (SCORE_DISPLAY_BEST_EN) display best score, sampled at frame start.
//   best_clr    : (SCORE_DISPLAY_BEST_EN) pulse clearing the best score.
//   an          : digit enables, active-low, bit k drives digit k.
//   seg         : segments {g,f,e,d,c,b,a}, active-low.
//   best_score  : (SCORE_DISPLAY_BEST_EN) registered best score.
//   new_best    : (SCORE_DISPLAY_BEST_EN) one-cycle pulse when best_score rises.
module score_display_scanner
  import score_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] bcd_score,
`ifdef SCORE_DISPLAY_BEST_EN
  input  logic        show_best,
  input  logic        best_clr,
  output logic [19:0] best_score,
  output logic        new_best,
`endif
  output logic [4:0]  an,
  output seg_t        seg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [19:0]   snap;
  logic [19:0]   src;
  logic [19:0]   cur;
  logic          frame_start;
  logic          cnt_wrap;
  logic [3:0]    cur_nib;
  logic          cur_blank;

  logic [3:0]    s1_nib;
  logic          s1_blank;
  logic [4:0]    s1_an;
  seg_t          dec_seg;

`ifdef SCORE_DISPLAY_BEST_EN
  // A frame start coinciding with a best update sees the pre-update value,
  // because best_score is read from its register here.
  assign src = show_best ? best_score : bcd_score;
`else
  assign src = bcd_score;
`endif

  assign frame_start = (idx == 3'd0) && (cnt == '0);
  assign cnt_wrap    = (cnt == CW'(SCAN_DIV - 1));

  // Stage 1 reads the incoming source directly in the frame-start cycle so
  // digit 0 of a frame already comes from the new snapshot.
  assign cur       = frame_start ? src : snap;
  assign cur_nib   = 4'(cur >> {idx, 2'b00});
  assign cur_blank = (idx != 3'd0) && ((cur >> {idx, 2'b00}) == 20'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= 3'd0;
      snap     <= 20'd0;
      s1_nib   <= 4'd0;
      s1_blank <= 1'b1;
      s1_an    <= 5'b11111;
      an       <= 5'b11111;
      seg      <= SEG_BLANK;
    end else begin
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_start) snap <= src;
      s1_nib   <= cur_nib;
      s1_blank <= cur_blank;
      s1_an    <= ~(5'b00001 << idx);
      an       <= s1_an;
      seg      <= dec_seg;
    end
  end

  bcd_to_seven_seg u_dec (
    .nib   (s1_nib),
    .blank (s1_blank),
    .seg   (dec_seg)
  );

`ifdef SCORE_DISPLAY_BEST_EN
  // Unsigned compare of the packed word orders BCD values correctly.
  always_ff @(posedge clk) begin
    if (rst || best_clr) begin
      best_score <= 20'd0;
      new_best   <= 1'b0;
    end else if (bcd_score > best_score) begin
      best_score <= bcd_score;
      new_best   <= 1'b1;
    end else begin
      new_best   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_score_display_scanner.sv
module tb_score_display_scanner;

  localparam int SD = 4;
  localparam int P  = 5 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] bcd_score = 20'd0;
  logic [4:0]  an;
  logic [6:0]  seg;
`ifdef SCORE_DISPLAY_BEST_EN
  logic        show_best = 1'b0;
  logic        best_clr = 1'b0;
  logic [19:0] best_score;
  logic        new_best;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_t = -1;     // cycles since last reset edge, -1 = unknown
  logic [19:0] exp_q[$];     // score sampled at each frame start
  logic [19:0] m_best = 20'd0;
  logic        m_nb = 1'b0;

  score_display_scanner #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_score  (bcd_score),
`ifdef SCORE_DISPLAY_BEST_EN
    .show_best  (show_best),
    .best_clr   (best_clr),
    .best_score (best_score),
    .new_best   (new_best),
`endif
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, m_t, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic compare_outputs();
    logic [4:0]  e_an;
    logic [6:0]  e_seg;
    logic [19:0] v;
    int u, k, f, hi;
    if (m_t < 0) return;
    if (m_t < 2) begin
      e_an  = 5'b11111;
      e_seg = 7'h7F;
    end else begin
      u  = m_t - 2;
      k  = (u / SD) % 5;
      f  = u / P;
      v  = exp_q[f];
      hi = int'(v) / (16 ** k);
      e_an  = 5'b11111 & ~(5'b00001 << k);
      e_seg = (k > 0 && hi == 0) ? 7'h7F : seg_of(hi % 16);
    end
    check_eq("an", {27'd0, an}, {27'd0, e_an});
    check_eq("seg", {25'd0, seg}, {25'd0, e_seg});
`ifdef SCORE_DISPLAY_BEST_EN
    check_eq("best_score", {12'd0, best_score}, {12'd0, m_best});
    check_eq("new_best", {31'd0, new_best}, {31'd0, m_nb});
`endif
  endtask

  // One clock: check outputs of the current cycle, drive inputs for the
  // next edge, and advance the model across that edge.
  task automatic tick(input bit r, input logic [19:0] sc, input bit sb, input bit clr);
    bit sb_e, clr_e;
    @(negedge clk);
    compare_outputs();
    rst = r;
    bcd_score = sc;
`ifdef SCORE_DISPLAY_BEST_EN
    show_best = sb;
    best_clr  = clr;
    sb_e = sb;
    clr_e = clr;
`else
    sb_e = 1'b0;
    clr_e = 1'b0;
`endif
    if (r) begin
      m_t = 0;
      exp_q.delete();
      m_best = 20'd0;
      m_nb = 1'b0;
    end else begin
      if (m_t % P == 0) exp_q.push_back(sb_e ? m_best : sc);
      m_nb   = !clr_e && (sc > m_best);
      m_best = clr_e ? 20'd0 : ((sc > m_best) ? sc : m_best);
      m_t++;
    end
  endtask

  task automatic run(input int n, input logic [19:0] sc);
    for (int i = 0; i < n; i++) tick(1'b0, sc, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 20'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [19:0] rand_score();
    logic [19:0] v;
    int nd;
    v  = 20'd0;
    nd = $urandom_range(1, 5);
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    logic [19:0] sc;
    // reset and first frame
    do_reset(3);
    run(25, 20'h00000);
    // full scan
    do_reset(1);
    run(45, 20'h02048);
    // snapshot stability: change while digit 1 scans
    do_reset(1);
    run(6, 20'h00128);
    run(40, 20'h00256);
    // invalid BCD
    do_reset(1);
    run(45, 20'h000A5);
`ifdef SCORE_DISPLAY_BEST_EN
    // best tracking
    do_reset(1);
    run(3, 20'h00016);
    run(3, 20'h00008);
    run(3, 20'h00032);
    tick(1'b0, 20'h00064, 1'b0, 1'b1);
    run(3, 20'h00000);
    run(25, 20'h00000);
`endif
    // mid-frame reset while digit 3 scans
    do_reset(1);
    run(13, 20'h12345);
    do_reset(1);
    run(30, 20'h99999);
    // randomized stream with occasional resets
    sc = rand_score();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) sc = rand_score();
      if ($urandom_range(0, 199) == 0)
        tick(1'b1, sc, 1'b0, 1'b0);
      else
        tick(1'b0, sc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0));
    end
    tick(1'b0, sc, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
